// File: rtl/dnn_accel_system_switch_poller.sv
// Avalon-MM read initiator that polls the switch PIO, debounces the sample and
// offers each newly stable value to the accelerator controller over valid/ready.
//
// state  | meaning
// WAIT   | interval timer counts down; issue a read once it is 0 and enable=1
// REQ    | avm_read held until the interconnect drops waitrequest
// RESP   | command accepted, waiting for readdatavalid
// EVAL   | debounce update, possible acceptance, timer reload
module dnn_accel_system_switch_poller #(
   parameter int         DATA_W        = 8,
   parameter int         POLL_INTERVAL = 1000,
   parameter int         STABLE_COUNT  = 3,
   parameter logic [1:0] PIO_ADDR      = 2'd0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   output logic [1:0]        avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic              avm_readdatavalid,
   input  logic [31:0]       avm_readdata,
   output logic [DATA_W-1:0] sw_value,
   output logic              sw_valid,
   input  logic              sw_ready,
   output logic              overflow,
   input  logic              clr_overflow
);

   localparam int TMR_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
   localparam int CNT_W = $clog2(STABLE_COUNT + 1);
   localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_INTERVAL - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_COUNT);

   typedef enum logic [1:0] {ST_WAIT, ST_REQ, ST_RESP, ST_EVAL} state_t;

   state_t            state, state_nxt;
   logic [TMR_W-1:0]  timer, timer_nxt;
   logic [DATA_W-1:0] sample;
   logic [DATA_W-1:0] candidate, candidate_nxt;
   logic [CNT_W-1:0]  stable_cnt, stable_cnt_nxt;
   logic              accept;
   logic              xfer;
   logic              unused_hi;

   // Only the low DATA_W bits of the PIO word carry switch state.
   assign unused_hi   = ^avm_readdata[31:DATA_W];
   assign avm_address = PIO_ADDR;
   assign xfer        = sw_valid & sw_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_WAIT;
         timer      <= '0;
         sample     <= '0;
         candidate  <= '0;
         stable_cnt <= '0;
      end else begin
         state      <= state_nxt;
         timer      <= timer_nxt;
         candidate  <= candidate_nxt;
         stable_cnt <= stable_cnt_nxt;
         if (state == ST_RESP && avm_readdatavalid)
            sample <= avm_readdata[DATA_W-1:0];
      end
   end

   always_comb begin
      state_nxt      = state;
      timer_nxt      = timer;
      candidate_nxt  = candidate;
      stable_cnt_nxt = stable_cnt;
      accept         = 1'b0;
      avm_read       = 1'b0;
      case (state)
         ST_WAIT: begin
            if (timer != '0)
               timer_nxt = timer - TMR_W'(1);
            else if (enable)
               state_nxt = ST_REQ;
         end
         ST_REQ: begin
            avm_read = 1'b1;
            if (!avm_waitrequest)
               state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (avm_readdatavalid)
               state_nxt = ST_EVAL;
         end
         ST_EVAL: begin
            if (sample == candidate) begin
               if (stable_cnt != CNT_MAX)
                  stable_cnt_nxt = stable_cnt + CNT_W'(1);
            end else begin
               candidate_nxt  = sample;
               stable_cnt_nxt = CNT_W'(1);
            end
            // Comparing against sw_value keeps a held value from being re-offered.
            accept    = (stable_cnt_nxt == CNT_MAX) && (candidate_nxt != sw_value);
            timer_nxt = TMR_RELOAD;
            state_nxt = ST_WAIT;
         end
         default: state_nxt = ST_WAIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sw_value <= '0;
         sw_valid <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            sw_value <= candidate_nxt;
            sw_valid <= 1'b1;
         end else if (xfer) begin
            sw_valid <= 1'b0;
         end
         // A set wins over a simultaneous clear.
         if (accept && sw_valid && !sw_ready)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dnn_accel_system_switch_poller.sv
// Scoreboard bench for the switch poller: a reactive Avalon slave feeds samples,
// a run-length reference model predicts accepted values, a monitor checks them.
module tb_dnn_accel_system_switch_poller;

   localparam int         P    = 10;
   localparam int         SC   = 3;
   localparam logic [1:0] ADDR = 2'd0;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [1:0]  avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic        avm_readdatavalid;
   logic [31:0] avm_readdata;
   logic [7:0]  sw_value;
   logic        sw_valid;
   logic        sw_ready;
   logic        overflow;
   logic        clr_overflow;

   always #5 clk = ~clk;

   dnn_accel_system_switch_poller #(
      .DATA_W(8), .POLL_INTERVAL(P), .STABLE_COUNT(SC), .PIO_ADDR(ADDR)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
      .avm_readdata(avm_readdata),
      .sw_value(sw_value), .sw_valid(sw_valid), .sw_ready(sw_ready),
      .overflow(overflow), .clr_overflow(clr_overflow)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
   endtask

   // ---------------- reactive Avalon slave ----------------
   int         ws_q[$];
   int         lat_q[$];
   logic [7:0] val_q[$];
   int         sl_phase = 0, ws_left = -1, lat_left = 0, cur_lat = 1;
   int         rd_cycles = 0, last_rd_cycles = 0, txn_done = 0;
   bit         in_resp = 0, stray_req = 0, rand_mode = 0, rdv_genuine = 0;
   logic [7:0] cur_val = 8'h00, def_val = 8'h00, rv = 8'h00;
   logic [31:0] rnd;

   initial begin
      avm_waitrequest   = 1'b1;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      forever begin
         @(posedge clk);
         #1;
         avm_readdatavalid = 1'b0;
         rdv_genuine       = 1'b0;
         in_resp           = 1'b0;
         if (!reset_n) begin
            sl_phase = 0; ws_left = -1; avm_waitrequest = 1'b1;
            continue;
         end
         if (stray_req) begin
            stray_req = 1'b0;
            rnd = $urandom();
            avm_readdata = {rnd[31:8], 8'hFF};
            avm_readdatavalid = 1'b1;
         end
         if (sl_phase == 0) begin
            if (avm_read) begin
               if (ws_left < 0) begin
                  ws_left = (ws_q.size() > 0) ? ws_q.pop_front()
                          : (rand_mode ? int'($urandom_range(0, 3)) : 0);
                  cur_lat = (lat_q.size() > 0) ? lat_q.pop_front()
                          : (rand_mode ? int'($urandom_range(1, 4)) : 1);
                  if (val_q.size() > 0) cur_val = val_q.pop_front();
                  else if (rand_mode) begin
                     if ($urandom_range(0, 3) == 0) rv = 8'($urandom_range(0, 7));
                     cur_val = rv;
                  end else cur_val = def_val;
                  rd_cycles = 0;
               end
               rd_cycles++;
               if (ws_left > 0) begin
                  avm_waitrequest = 1'b1;
                  ws_left--;
               end else begin
                  avm_waitrequest = 1'b0;
                  ws_left  = -1;
                  sl_phase = 1;
                  lat_left = cur_lat;
               end
            end else begin
               avm_waitrequest = 1'b1;
            end
         end else begin
            avm_waitrequest = 1'b1;
            in_resp = 1'b1;
            if (lat_left <= 1) begin
               rnd = $urandom();
               avm_readdata      = {rnd[31:8], cur_val};
               avm_readdatavalid = 1'b1;
               rdv_genuine       = 1'b1;
               sl_phase          = 0;
               last_rd_cycles    = rd_cycles;
               txn_done++;
            end else begin
               lat_left--;
            end
         end
      end
   end

   // ---------------- reference model ----------------
   // Accept when the trailing run of identical samples reaches SC and the run
   // value differs from the last accepted one; the consumer handshake decides
   // whether the pending value was delivered or overwritten.
   bit         m_pending = 0, m_ovf = 0, acc_due = 0, m_xfer, m_set;
   logic [7:0] m_swv = 8'h00, acc_val = 8'h00, run_val = 8'h00, smp;
   int         run_len = 0;
   logic [7:0] exp_q[$];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_pending = 0; m_ovf = 0; acc_due = 0; m_swv = 8'h00;
         run_val = 8'h00; run_len = 0;
         exp_q.delete();
      end else begin
         m_xfer = m_pending && sw_ready;
         m_set  = 0;
         if (acc_due) begin
            if (m_pending && !m_xfer) begin
               m_set = 1;
               if (exp_q.size() > 0) void'(exp_q.pop_back());
            end
            exp_q.push_back(acc_val);
            m_swv     = acc_val;
            m_pending = 1;
         end else if (m_xfer) begin
            m_pending = 0;
         end
         if (m_set) m_ovf = 1;
         else if (clr_overflow) m_ovf = 0;
         acc_due = 0;
         if (avm_readdatavalid && rdv_genuine) begin
            smp = avm_readdata[7:0];
            if (run_len > 0 && smp == run_val) run_len++;
            else begin run_val = smp; run_len = 1; end
            if (run_len >= SC && run_val != m_swv) begin
               acc_due = 1;
               acc_val = run_val;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   bit         prev_read = 0, rec_rises = 0;
   int         acc_cnt = 0, xfer_cnt = 0;
   int         rises[$];
   logic [7:0] last_xfer = 8'h00;

   always @(negedge clk) begin
      chk("sw_valid", {31'd0, sw_valid}, {31'd0, m_pending});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("sw_value", {24'd0, sw_value}, {24'd0, m_swv});
      if (avm_read) chk("address", {30'd0, avm_address}, {30'd0, ADDR});
      if (in_resp) chk("single_outstanding", {31'd0, avm_read}, 32'd0);
      if (avm_read && !avm_waitrequest) acc_cnt++;
      if (sw_valid && sw_ready) begin
         if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL xfer_value: got 0x%0h, expected no pending value (cycle %0d)", sw_value, cyc);
         end else begin
            chk("xfer_value", {24'd0, sw_value}, {24'd0, exp_q.pop_front()});
         end
         xfer_cnt++;
         last_xfer = sw_value;
      end
      if (rec_rises && avm_read && !prev_read) rises.push_back(cyc);
      prev_read = avm_read;
   end

   task automatic cyc_n(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_polls(input int n, input string nm);
      int target;
      int lim;
      target = txn_done + n;
      lim = 0;
      while (txn_done < target && lim < n * 300) begin
         @(posedge clk);
         lim++;
      end
      if (txn_done < target) fail_now(nm);
      cyc_n(3);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   int snap;
   int lim;

   initial begin
      reset_n = 1'b0; enable = 1'b0; sw_ready = 1'b0; clr_overflow = 1'b0;
      cyc_n(2);
      chk("rst_read", {31'd0, avm_read}, 32'd0);
      chk("rst_address", {30'd0, avm_address}, {30'd0, ADDR});
      chk("rst_valid", {31'd0, sw_valid}, 32'd0);
      chk("rst_value", {24'd0, sw_value}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      reset_n = 1'b1;
      cyc_n(3);
      chk("idle_no_read", {31'd0, avm_read}, 32'd0);

      // switches at 0x00: read issues one cycle after enable, nothing accepted
      sw_ready = 1'b1; def_val = 8'h00;
      repeat (4) val_q.push_back(8'h00);
      enable = 1'b1;
      @(negedge clk); chk("first_read_early", {31'd0, avm_read}, 32'd0);
      @(negedge clk); chk("first_read", {31'd0, avm_read}, 32'd1);
      wait_polls(4, "zero_polls");
      chk("zero_no_accept", xfer_cnt, 0);

      // steady 0xA5 with period measurement
      sw_ready = 1'b0; def_val = 8'hA5;
      rises.delete(); rec_rises = 1'b1;
      repeat (3) val_q.push_back(8'hA5);
      wait_polls(3, "a5_polls");
      rec_rises = 1'b0;
      chk("rise_count", rises.size(), 3);
      if (rises.size() == 3) begin
         chk("period_1", rises[1] - rises[0], P + 3);
         chk("period_2", rises[2] - rises[1], P + 3);
      end
      chk("a5_value", {24'd0, sw_value}, 32'h0000_00A5);
      chk("a5_valid", {31'd0, sw_valid}, 32'd1);
      sw_ready = 1'b1; cyc_n(1); sw_ready = 1'b0;
      chk("a5_consumed", {31'd0, sw_valid}, 32'd0);

      // glitch sequence
      sw_ready = 1'b1; def_val = 8'h3C; snap = xfer_cnt;
      val_q.push_back(8'h3C); val_q.push_back(8'h3C); val_q.push_back(8'h00);
      val_q.push_back(8'h3C); val_q.push_back(8'h3C); val_q.push_back(8'h3C);
      wait_polls(6, "glitch_polls");
      chk("glitch_accepts", xfer_cnt - snap, 1);
      chk("glitch_value", {24'd0, last_xfer}, 32'h0000_003C);

      // waitrequest stall of 5 cycles, 4-cycle read latency
      snap = acc_cnt;
      ws_q.push_back(5); lat_q.push_back(4); val_q.push_back(8'h3C);
      wait_polls(1, "stall_poll");
      chk("stall_read_cycles", last_rd_cycles, 6);
      chk("stall_one_cmd", acc_cnt - snap, 1);

      // coalescing and overflow
      sw_ready = 1'b0; def_val = 8'h22;
      repeat (3) val_q.push_back(8'h11);
      repeat (3) val_q.push_back(8'h22);
      wait_polls(6, "ovf_polls");
      chk("ovf_value", {24'd0, sw_value}, 32'h0000_0022);
      chk("ovf_valid", {31'd0, sw_valid}, 32'd1);
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      clr_overflow = 1'b1; cyc_n(1); clr_overflow = 1'b0;
      chk("ovf_cleared", {31'd0, overflow}, 32'd0);
      sw_ready = 1'b1; cyc_n(1); sw_ready = 1'b0;
      chk("ovf_consumed", {31'd0, sw_valid}, 32'd0);

      // reset while waiting in RESP, then a stray readdatavalid
      def_val = 8'h44;
      repeat (3) val_q.push_back(8'h44);
      wait_polls(3, "pre_reset_polls");
      chk("pre_reset_valid", {31'd0, sw_valid}, 32'd1);
      lat_q.push_back(8); val_q.push_back(8'h77);
      lim = 0;
      while (!in_resp && lim < 200) begin @(posedge clk); #2; lim++; end
      if (!in_resp) fail_now("reach_resp");
      cyc_n(2);
      reset_n = 1'b0; enable = 1'b0;
      #1;
      chk("mid_rst_read", {31'd0, avm_read}, 32'd0);
      chk("mid_rst_valid", {31'd0, sw_valid}, 32'd0);
      chk("mid_rst_value", {24'd0, sw_value}, 32'd0);
      chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
      cyc_n(2);
      reset_n = 1'b1; stray_req = 1'b1;
      cyc_n(4);
      chk("stray_value", {24'd0, sw_value}, 32'd0);
      chk("stray_valid", {31'd0, sw_valid}, 32'd0);
      chk("stray_no_read", {31'd0, avm_read}, 32'd0);
      def_val = 8'h5A; enable = 1'b1;
      repeat (3) val_q.push_back(8'h5A);
      wait_polls(3, "restart_polls");
      chk("restart_value", {24'd0, sw_value}, 32'h0000_005A);
      chk("restart_valid", {31'd0, sw_valid}, 32'd1);

      // randomized traffic
      rand_mode = 1'b1;
      for (int i = 0; i < 2500; i++) begin
         @(posedge clk); #2;
         sw_ready     = ($urandom_range(0, 3) != 0);
         clr_overflow = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 63) == 0) enable = ~enable;
      end
      clr_overflow = 1'b0; sw_ready = 1'b1; enable = 1'b0;
      cyc_n(40);
      chk("drain_queue", exp_q.size(), 0);
      chk("drain_valid", {31'd0, sw_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
